// File: rtl/fft_mag_peak_if.sv
// Bin stream in, magnitude stream and frame peak out, for fft_mag_peak.
//   master : FFT side; drives next/X_re/X_im and observes the results.
//   slave  : fft_mag_peak side; drives next_out, mag*, peak*, frame_err.
interface fft_mag_peak_if #(
   parameter int unsigned DATA_W   = 12,
   parameter int unsigned N_POINTS = 64
);
   localparam int unsigned BIN_W = $clog2(N_POINTS);

   logic                     next;
   logic signed [DATA_W-1:0] X_re;
   logic signed [DATA_W-1:0] X_im;
   logic                     next_out;
   logic                     mag_valid;
   logic [DATA_W-1:0]        mag;
   logic [BIN_W-1:0]         mag_bin;
   logic                     peak_valid;
   logic [BIN_W-1:0]         peak_bin;
   logic [DATA_W-1:0]        peak_mag;
   logic                     frame_err;

   modport master (
      output next, X_re, X_im,
      input  next_out, mag_valid, mag, mag_bin, peak_valid, peak_bin, peak_mag, frame_err
   );

   modport slave (
      input  next, X_re, X_im,
      output next_out, mag_valid, mag, mag_bin, peak_valid, peak_bin, peak_mag, frame_err
   );
endinterface

// File: rtl/fft_mag_peak.sv
// Streaming FFT magnitude post-processor with per-frame peak search.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bus        : fft_mag_peak_if slave; next/X_re/X_im in, magnitude stream
//                (next_out, mag_valid, mag, mag_bin), frame peak
//                (peak_valid, peak_bin, peak_mag) and frame_err out.
// Bins are accepted one per cycle after a `next` pulse; mag appears 3 cycles
// after a bin is accepted.
module fft_mag_peak #(
   parameter int unsigned DATA_W        = 12,
   parameter int unsigned N_POINTS      = 64,
   parameter int unsigned MAG_MODE      = 0,
   parameter int unsigned SKIP_DC       = 1,
   parameter int unsigned HALF_SPECTRUM = 1
) (
   input  logic          clk,
   input  logic          reset,
   fft_mag_peak_if.slave bus
);
   localparam int unsigned BIN_W = $clog2(N_POINTS);
   localparam int unsigned AW    = DATA_W - 1;
   localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(N_POINTS - 1);

   localparam logic [0:0] S_IDLE   = 1'b0;
   localparam logic [0:0] S_ACTIVE = 1'b1;

   // |x| with the most-negative code saturated to the largest positive value
   function automatic logic [AW-1:0] sat_abs(input logic [DATA_W-1:0] x);
      logic [DATA_W-1:0] neg;
      neg = -x;
      if (!x[DATA_W-1])       sat_abs = x[AW-1:0];
      else if (neg[DATA_W-1]) sat_abs = {AW{1'b1}};
      else                    sat_abs = neg[AW-1:0];
   endfunction

   logic [0:0]        state_q, state_d;
   logic [BIN_W-1:0]  cnt_q, cnt_d;
   logic              abort_c, accept_c;
   logic              v1_q, v1_d, v2_q, v2_d;
   logic [BIN_W-1:0]  bin1_q, bin1_d, bin2_q, bin2_d;
   logic [AW-1:0]     are1_q, are1_d, aim1_q, aim1_d;
   logic [DATA_W-1:0] mag_c;
   logic              nx1_q, nx1_d, nx2_q, nx2_d;
   logic              next_out_q, next_out_d, frame_err_q, frame_err_d;
   logic              mag_valid_q, mag_valid_d;
   logic [DATA_W-1:0] mag_q, mag_d;
   logic [BIN_W-1:0]  mag_bin_q, mag_bin_d;
   logic              have_q, have_d, elig_c, take_c;
   logic [BIN_W-1:0]  run_bin_q, run_bin_d;
   logic [DATA_W-1:0] run_mag_q, run_mag_d;
   logic              peak_valid_q, peak_valid_d;
   logic [BIN_W-1:0]  peak_bin_q, peak_bin_d;
   logic [DATA_W-1:0] peak_mag_q, peak_mag_d;

   // Input FSM: any `next` (re)starts a frame at bin 0
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      abort_c = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.next) begin
               state_d = S_ACTIVE;
               cnt_d   = '0;
            end
         end
         default: begin
            if (bus.next) begin
               cnt_d   = '0;
               abort_c = (cnt_q != LAST_BIN);
            end else if (cnt_q == LAST_BIN) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
      endcase
   end

   assign accept_c = (state_q == S_ACTIVE);

   // Stage 1 (abs), stage-2 sideband, output stage and next_out delay line.
   // Idle slots carry zeros so mag/mag_bin read 0 when mag_valid is low.
   always_comb begin
      v1_d        = accept_c;
      bin1_d      = accept_c ? cnt_q : '0;
      are1_d      = accept_c ? sat_abs(bus.X_re) : '0;
      aim1_d      = accept_c ? sat_abs(bus.X_im) : '0;
      v2_d        = v1_q;
      bin2_d      = bin1_q;
      mag_valid_d = v2_q;
      mag_bin_d   = bin2_q;
      mag_d       = mag_c;
      nx1_d       = bus.next;
      nx2_d       = nx1_q;
      next_out_d  = nx2_q;
      frame_err_d = abort_c;
   end

   if (MAG_MODE == 0) begin : g_abm
      // max + 0.375*min approximation of sqrt(re^2 + im^2)
      logic [AW-1:0] hi_q, hi_d, lo_q, lo_d;
      always_comb begin
         hi_d = (are1_q >= aim1_q) ? are1_q : aim1_q;
         lo_d = (are1_q >= aim1_q) ? aim1_q : are1_q;
      end
      always_ff @(posedge clk) begin
         if (reset) begin
            hi_q <= '0;
            lo_q <= '0;
         end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
         end
      end
      assign mag_c = DATA_W'(hi_q) + DATA_W'(lo_q >> 2) + DATA_W'(lo_q >> 3);
   end else begin : g_pow
      // Power scaled back into DATA_W bits
      localparam int unsigned SQ_W = 2 * DATA_W - 2;
      logic [SQ_W-1:0] sre_q, sre_d, sim_q, sim_d;
      logic [SQ_W:0]   sum_c;
      always_comb begin
         sre_d = SQ_W'(are1_q) * SQ_W'(are1_q);
         sim_d = SQ_W'(aim1_q) * SQ_W'(aim1_q);
      end
      always_ff @(posedge clk) begin
         if (reset) begin
            sre_q <= '0;
            sim_q <= '0;
         end else begin
            sre_q <= sre_d;
            sim_q <= sim_d;
         end
      end
      assign sum_c = (SQ_W + 1)'(sre_q) + (SQ_W + 1)'(sim_q);
      assign mag_c = DATA_W'(sum_c >> (DATA_W - 1));
   end

   // Peak tracker on the output stream; a bin-0 sample opens a new frame,
   // which also drops whatever an aborted frame had collected.
   always_comb begin
      have_d       = have_q;
      run_bin_d    = run_bin_q;
      run_mag_d    = run_mag_q;
      peak_valid_d = 1'b0;
      peak_bin_d   = peak_bin_q;
      peak_mag_d   = peak_mag_q;
      elig_c = mag_valid_q
             && !((SKIP_DC != 0) && (mag_bin_q == '0))
             && !((HALF_SPECTRUM != 0) && mag_bin_q[BIN_W-1]);
      take_c = elig_c && (!(have_q && (mag_bin_q != '0)) || (mag_q > run_mag_q));
      if (mag_valid_q && (mag_bin_q == '0)) have_d = 1'b0;
      if (take_c) begin
         have_d    = 1'b1;
         run_bin_d = mag_bin_q;
         run_mag_d = mag_q;
      end
      if (mag_valid_q && (mag_bin_q == LAST_BIN)) begin
         peak_valid_d = 1'b1;
         peak_bin_d   = run_bin_d;
         peak_mag_d   = run_mag_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         v1_q         <= 1'b0;
         v2_q         <= 1'b0;
         bin1_q       <= '0;
         bin2_q       <= '0;
         are1_q       <= '0;
         aim1_q       <= '0;
         nx1_q        <= 1'b0;
         nx2_q        <= 1'b0;
         next_out_q   <= 1'b0;
         frame_err_q  <= 1'b0;
         mag_valid_q  <= 1'b0;
         mag_q        <= '0;
         mag_bin_q    <= '0;
         have_q       <= 1'b0;
         run_bin_q    <= '0;
         run_mag_q    <= '0;
         peak_valid_q <= 1'b0;
         peak_bin_q   <= '0;
         peak_mag_q   <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         v1_q         <= v1_d;
         v2_q         <= v2_d;
         bin1_q       <= bin1_d;
         bin2_q       <= bin2_d;
         are1_q       <= are1_d;
         aim1_q       <= aim1_d;
         nx1_q        <= nx1_d;
         nx2_q        <= nx2_d;
         next_out_q   <= next_out_d;
         frame_err_q  <= frame_err_d;
         mag_valid_q  <= mag_valid_d;
         mag_q        <= mag_d;
         mag_bin_q    <= mag_bin_d;
         have_q       <= have_d;
         run_bin_q    <= run_bin_d;
         run_mag_q    <= run_mag_d;
         peak_valid_q <= peak_valid_d;
         peak_bin_q   <= peak_bin_d;
         peak_mag_q   <= peak_mag_d;
      end
   end

   assign bus.next_out   = next_out_q;
   assign bus.mag_valid  = mag_valid_q;
   assign bus.mag        = mag_q;
   assign bus.mag_bin    = mag_bin_q;
   assign bus.peak_valid = peak_valid_q;
   assign bus.peak_bin   = peak_bin_q;
   assign bus.peak_mag   = peak_mag_q;
   assign bus.frame_err  = frame_err_q;
endmodule

// File: tb/tb_fft_mag_peak.sv
// Directed bench for fft_mag_peak: three instances (N=8, DATA_W=12) share one
// input stream: a = MODE0/SKIP_DC, b = MODE1/SKIP_DC, c = MODE0 without SKIP_DC.
// Each scenario is a per-cycle table of inputs and hand-computed outputs.
module tb_fft_mag_peak;
   localparam int unsigned DW = 12;
   localparam int unsigned NP = 8;
   localparam int unsigned BW = 3;
   localparam int unsigned NC = 32;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 nxt;
   logic signed [DW-1:0] xre, xim;

   always #5 clk = ~clk;

   fft_mag_peak_if #(.DATA_W(DW), .N_POINTS(NP)) if_a ();
   fft_mag_peak_if #(.DATA_W(DW), .N_POINTS(NP)) if_b ();
   fft_mag_peak_if #(.DATA_W(DW), .N_POINTS(NP)) if_c ();

   assign if_a.next = nxt;
   assign if_a.X_re = xre;
   assign if_a.X_im = xim;
   assign if_b.next = nxt;
   assign if_b.X_re = xre;
   assign if_b.X_im = xim;
   assign if_c.next = nxt;
   assign if_c.X_re = xre;
   assign if_c.X_im = xim;

   fft_mag_peak #(.DATA_W(DW), .N_POINTS(NP), .MAG_MODE(0), .SKIP_DC(1), .HALF_SPECTRUM(1))
      dut_a (.clk(clk), .reset(reset), .bus(if_a));
   fft_mag_peak #(.DATA_W(DW), .N_POINTS(NP), .MAG_MODE(1), .SKIP_DC(1), .HALF_SPECTRUM(1))
      dut_b (.clk(clk), .reset(reset), .bus(if_b));
   fft_mag_peak #(.DATA_W(DW), .N_POINTS(NP), .MAG_MODE(0), .SKIP_DC(0), .HALF_SPECTRUM(1))
      dut_c (.clk(clk), .reset(reset), .bus(if_c));

   // Frame stimulus: 0 = reference frame, 1 = tie/DC/upper-half frame, 2 = big bin 2
   int f_re [3][8] = '{'{0, 300, 50, -2048, 10, 0, 0, 0},
                       '{1000, 200, 200, 0, -5, 1500, 0, 0},
                       '{0, 0, 2047, 0, 0, 0, 0, 0}};
   int f_im [3][8] = '{'{0, -400, 50, 0, 0, 0, 0, 0},
                       '{0, 0, 0, 0, -7, 0, 0, 0},
                       '{0, 0, 2047, 0, 0, 0, 0, 0}};
   // Hand-computed magnitudes [dut][frame][bin]
   int m_mag [3][3][8] = '{
      '{'{0, 512, 68, 2047, 10, 0, 0, 0}, '{1000, 200, 200, 0, 8, 1500, 0, 0}, '{0, 0, 2813, 0, 0, 0, 0, 0}},
      '{'{0, 122, 2, 2046, 0, 0, 0, 0},   '{488, 19, 19, 0, 0, 1098, 0, 0},    '{0, 0, 4092, 0, 0, 0, 0, 0}},
      '{'{0, 512, 68, 2047, 10, 0, 0, 0}, '{1000, 200, 200, 0, 8, 1500, 0, 0}, '{0, 0, 2813, 0, 0, 0, 0, 0}}};
   // Expected frame peaks [dut][frame]
   int pk_bin [3][3] = '{'{3, 1, 0}, '{3, 1, 0}, '{3, 0, 0}};
   int pk_mag [3][3] = '{'{2047, 200, 0}, '{2046, 19, 0}, '{2047, 1000, 0}};

   // Per-cycle schedule
   bit s_nxt [NC];
   bit s_rst [NC];
   int s_re  [NC];
   int s_im  [NC];
   bit e_nout [NC];
   bit e_mv   [NC];
   bit e_pv   [NC];
   bit e_fe   [NC];
   int e_bin  [NC];
   int e_mag  [3][NC];
   int e_pkb  [3][NC];
   int e_pkm  [3][NC];

   int hb [3];
   int hm [3];
   int checks   = 0;
   int failures = 0;

   task automatic chk(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, c, obs, exp);
      end
   endtask

   task automatic chk_dut(input string d, input int di, input int c,
                          input logic nout, input logic mv, input logic [DW-1:0] mg,
                          input logic [BW-1:0] bn, input logic pv, input logic [BW-1:0] pb,
                          input logic [DW-1:0] pm, input logic fe);
      chk({d, ".next_out"},   c, 32'(nout), 32'(e_nout[c]));
      chk({d, ".mag_valid"},  c, 32'(mv),   32'(e_mv[c]));
      chk({d, ".mag"},        c, 32'(mg),   32'(e_mag[di][c]));
      chk({d, ".mag_bin"},    c, 32'(bn),   32'(e_bin[c]));
      chk({d, ".peak_valid"}, c, 32'(pv),   32'(e_pv[c]));
      chk({d, ".peak_bin"},   c, 32'(pb),   32'(hb[di]));
      chk({d, ".peak_mag"},   c, 32'(pm),   32'(hm[di]));
      chk({d, ".frame_err"},  c, 32'(fe),   32'(e_fe[c]));
   endtask

   task automatic clear_sched();
      for (int c = 0; c < int'(NC); c++) begin
         s_nxt[c] = 1'b0; s_rst[c] = 1'b0; s_re[c] = 0; s_im[c] = 0;
         e_nout[c] = 1'b0; e_mv[c] = 1'b0; e_pv[c] = 1'b0; e_fe[c] = 1'b0; e_bin[c] = 0;
         for (int d = 0; d < 3; d++) begin
            e_mag[d][c] = 0; e_pkb[d][c] = 0; e_pkm[d][c] = 0;
         end
      end
   endtask

   // `next` at t0, nb bins from frame fid; a full frame also expects its peak
   task automatic sched_frame(input int t0, input int fid, input int nb);
      s_nxt[t0]    = 1'b1;
      e_nout[t0+3] = 1'b1;
      for (int j = 0; j < nb; j++) begin
         s_re[t0+1+j]  = f_re[fid][j];
         s_im[t0+1+j]  = f_im[fid][j];
         e_mv[t0+4+j]  = 1'b1;
         e_bin[t0+4+j] = j;
         for (int d = 0; d < 3; d++) e_mag[d][t0+4+j] = m_mag[d][fid][j];
      end
      if (nb == int'(NP)) begin
         e_pv[t0+4+NP] = 1'b1;
         for (int d = 0; d < 3; d++) begin
            e_pkb[d][t0+4+NP] = pk_bin[d][fid];
            e_pkm[d][t0+4+NP] = pk_mag[d][fid];
         end
      end
   endtask

   task automatic run_sched(input int ncyc);
      for (int c = 0; c < ncyc; c++) begin
         reset = s_rst[c];
         nxt   = s_nxt[c];
         xre   = DW'(s_re[c]);
         xim   = DW'(s_im[c]);
         if (e_pv[c]) begin
            for (int d = 0; d < 3; d++) begin
               hb[d] = e_pkb[d][c];
               hm[d] = e_pkm[d][c];
            end
         end
         chk_dut("a", 0, c, if_a.next_out, if_a.mag_valid, if_a.mag, if_a.mag_bin,
                 if_a.peak_valid, if_a.peak_bin, if_a.peak_mag, if_a.frame_err);
         chk_dut("b", 1, c, if_b.next_out, if_b.mag_valid, if_b.mag, if_b.mag_bin,
                 if_b.peak_valid, if_b.peak_bin, if_b.peak_mag, if_b.frame_err);
         chk_dut("c", 2, c, if_c.next_out, if_c.mag_valid, if_c.mag, if_c.mag_bin,
                 if_c.peak_valid, if_c.peak_bin, if_c.peak_mag, if_c.frame_err);
         @(posedge clk);
         #1;
         if (s_rst[c]) begin
            for (int d = 0; d < 3; d++) begin
               hb[d] = 0;
               hm[d] = 0;
            end
         end
      end
      reset = 1'b0;
      nxt   = 1'b0;
      xre   = '0;
      xim   = '0;
   endtask

   initial begin
      reset = 1'b1;
      nxt   = 1'b0;
      xre   = '0;
      xim   = '0;
      for (int d = 0; d < 3; d++) begin
         hb[d] = 0;
         hm[d] = 0;
      end
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      reset = 1'b0;

      // Idle with data but no `next`: every output stays 0
      clear_sched();
      for (int c = 0; c < 12; c++) s_re[c] = 100;
      run_sched(12);

      // Reference frame
      clear_sched();
      sched_frame(0, 0, NP);
      run_sched(14);

      // Tie, DC skip and upper-half exclusion
      clear_sched();
      sched_frame(0, 1, NP);
      run_sched(14);

      // `next` at k=4 aborts a frame carrying a large bin 2
      clear_sched();
      sched_frame(0, 2, 5);
      sched_frame(5, 1, NP);
      e_fe[6] = 1'b1;
      run_sched(19);

      // Reset while bin 5 is presented, then a clean frame
      clear_sched();
      sched_frame(0, 0, 3);
      for (int j = 3; j < 6; j++) begin
         s_re[1+j] = f_re[0][j];
         s_im[1+j] = f_im[0][j];
      end
      s_rst[6] = 1'b1;
      sched_frame(8, 1, NP);
      run_sched(22);

      // Back-to-back frames, `next` on the last-bin cycle
      clear_sched();
      sched_frame(0, 0, NP);
      sched_frame(8, 1, NP);
      run_sched(22);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
